// File: rtl/morse_stream_decoder_if.sv
// morse_stream_decoder_if
//   Groups the symbol inputs, the FIFO read port and the status outputs of
//   morse_stream_decoder.
//
//   Signal protocol:
//     SHORT / LONG / END_CHAR / CLR are single-cycle pulses. They are sampled
//     on every rising clock edge and need no ready. RD_DATA is the
//     first-word-fall-through head and is valid whenever EMPTY=0; it works as
//     valid=~EMPTY with RD_EN as ready, so a pop happens on an edge where
//     RD_EN=1 and EMPTY=0. RD_EN while EMPTY=1 has no effect.
//
//   Ports:
//     master : drives CLR, SHORT, LONG, END_CHAR, RD_EN; observes the rest
//     slave  : the decoder side
//     dbg_state exposes the collector FSM state (0 IDLE, 1 COLLECT, 2 COMMIT).
interface morse_stream_decoder_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          CLR;
    logic          SHORT;
    logic          LONG;
    logic          END_CHAR;
    logic          RD_EN;
    logic [5:0]    RD_DATA;
    logic          EMPTY;
    logic          FULL;
    logic [CW-1:0] COUNT;
    logic          STROBE;
    logic [5:0]    LAST_CODE;
    logic          ERR_CODE;
    logic          OVERFLOW;
    logic [1:0]    dbg_state;

    modport master (
        output CLR, SHORT, LONG, END_CHAR, RD_EN,
        input  RD_DATA, EMPTY, FULL, COUNT, STROBE, LAST_CODE, ERR_CODE,
               OVERFLOW, dbg_state
    );

    modport slave (
        input  CLR, SHORT, LONG, END_CHAR, RD_EN,
        output RD_DATA, EMPTY, FULL, COUNT, STROBE, LAST_CODE, ERR_CODE,
               OVERFLOW, dbg_state
    );
endinterface

// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder
//   Collects dot/dash pulses into a character, closes it on END_CHAR or after
//   GAP_CYCLES idle cycles, decodes it (A..Z = 0..25, optional digits
//   0..9 = 26..35, invalid = 6'h3F) and queues the code in a FWFT FIFO.
//
//   Ports:
//     CLK      rising-edge system clock
//     RESET_N  asynchronous active-low reset
//     bus      morse_stream_decoder_if.slave: symbol pulses, CLR, FIFO read
//              port, status (EMPTY/FULL/COUNT/STROBE/LAST_CODE/ERR_CODE/
//              OVERFLOW) and dbg_state
module morse_stream_decoder #(
    parameter int MAX_SYMS   = 5,
    parameter int GAP_CYCLES = 50_000_000,
    parameter int FIFO_DEPTH = 16,
    parameter int DIGITS_EN  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    morse_stream_decoder_if.slave bus
);
    localparam int  AW         = $clog2(FIFO_DEPTH);
    localparam int  CW         = AW + 1;
    localparam int  CNTW       = $clog2(MAX_SYMS + 1);
    localparam int  TW         = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int  GAP_LAST   = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam bit  AUTO_CLOSE = (GAP_CYCLES > 0);
    localparam logic [5:0] CODE_INVALID = 6'h3F;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_COMMIT  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [MAX_SYMS-1:0] sym_q, sym_d, base_sym;
    logic [CNTW-1:0]     cnt_q, cnt_d, base_cnt;
    logic                inv_q, inv_d, base_inv;
    logic [TW-1:0]       tmr_q, tmr_d;

    logic                sym_pulse;
    logic                commit;
    logic [5:0]          commit_code;

    logic [5:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q;
    logic                fifo_empty, fifo_full, do_pop, do_push;
    logic                overflow_q, strobe_q, err_q;
    logic [5:0]          last_code_q;

    // Pattern is right-aligned, first symbol in the highest used bit;
    // dot = 0, dash = 1.
    function automatic logic [5:0] decode(input logic [2:0] n,
                                          input logic [4:0] p,
                                          input logic       dig_en);
        logic [5:0] c;
        c = CODE_INVALID;
        case (n)
            3'd1: case (p)
                5'b00000: c = 6'd4;   // E
                5'b00001: c = 6'd19;  // T
                default:  c = CODE_INVALID;
            endcase
            3'd2: case (p)
                5'b00000: c = 6'd8;   // I
                5'b00001: c = 6'd0;   // A
                5'b00010: c = 6'd13;  // N
                5'b00011: c = 6'd12;  // M
                default:  c = CODE_INVALID;
            endcase
            3'd3: case (p)
                5'b00000: c = 6'd18;  // S
                5'b00001: c = 6'd20;  // U
                5'b00010: c = 6'd17;  // R
                5'b00011: c = 6'd22;  // W
                5'b00100: c = 6'd3;   // D
                5'b00101: c = 6'd10;  // K
                5'b00110: c = 6'd6;   // G
                5'b00111: c = 6'd14;  // O
                default:  c = CODE_INVALID;
            endcase
            3'd4: case (p)
                5'b00000: c = 6'd7;   // H
                5'b00001: c = 6'd21;  // V
                5'b00010: c = 6'd5;   // F
                5'b00100: c = 6'd11;  // L
                5'b00110: c = 6'd15;  // P
                5'b00111: c = 6'd9;   // J
                5'b01000: c = 6'd1;   // B
                5'b01001: c = 6'd23;  // X
                5'b01010: c = 6'd2;   // C
                5'b01011: c = 6'd24;  // Y
                5'b01100: c = 6'd25;  // Z
                5'b01101: c = 6'd16;  // Q
                default:  c = CODE_INVALID;
            endcase
            3'd5: if (dig_en) begin
                case (p)
                    5'b11111: c = 6'd26;  // 0
                    5'b01111: c = 6'd27;  // 1
                    5'b00111: c = 6'd28;  // 2
                    5'b00011: c = 6'd29;  // 3
                    5'b00001: c = 6'd30;  // 4
                    5'b00000: c = 6'd31;  // 5
                    5'b10000: c = 6'd32;  // 6
                    5'b11000: c = 6'd33;  // 7
                    5'b11100: c = 6'd34;  // 8
                    5'b11110: c = 6'd35;  // 9
                    default:  c = CODE_INVALID;
                endcase
            end
            default: c = CODE_INVALID;
        endcase
        return c;
    endfunction

    assign sym_pulse   = bus.SHORT | bus.LONG;
    assign commit      = (state_q == S_COMMIT);
    assign commit_code = inv_q ? CODE_INVALID
                               : decode(3'(cnt_q), 5'(sym_q), DIGITS_EN != 0);

    // Next-state and collector update.
    always_comb begin
        state_d  = state_q;
        sym_d    = sym_q;
        cnt_d    = cnt_q;
        inv_d    = inv_q;
        tmr_d    = tmr_q;
        // Outside COLLECT a symbol always starts a fresh character
        // (this covers a symbol landing in the COMMIT cycle).
        base_sym = sym_q;
        base_cnt = cnt_q;
        base_inv = inv_q;
        if (state_q != S_COLLECT) begin
            base_sym = '0;
            base_cnt = '0;
            base_inv = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (sym_pulse) state_d = bus.END_CHAR ? S_COMMIT : S_COLLECT;
            end
            S_COLLECT: begin
                // Timer holds GAP_CYCLES-1 on the edge that enters COMMIT,
                // which lands COMMIT exactly GAP_CYCLES edges after the symbol.
                if (bus.END_CHAR)
                    state_d = S_COMMIT;
                else if (!sym_pulse && AUTO_CLOSE && tmr_q == TW'(GAP_LAST))
                    state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (sym_pulse) state_d = bus.END_CHAR ? S_COMMIT : S_COLLECT;
                else           state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (sym_pulse) begin
            tmr_d = '0;
            sym_d = base_sym;
            cnt_d = base_cnt;
            inv_d = base_inv;
            if (bus.SHORT && bus.LONG) begin
                inv_d = 1'b1;
            end else if (base_cnt == CNTW'(MAX_SYMS)) begin
                inv_d = 1'b1;
            end else begin
                sym_d = {base_sym[MAX_SYMS-2:0], bus.LONG};
                cnt_d = base_cnt + CNTW'(1);
            end
        end else if (state_q == S_COMMIT) begin
            sym_d = '0;
            cnt_d = '0;
            inv_d = 1'b0;
            tmr_d = '0;
        end else if (state_q == S_COLLECT && AUTO_CLOSE && tmr_q != TW'(GAP_LAST)) begin
            tmr_d = tmr_q + TW'(1);
        end
    end

    // FIFO control. A full FIFO still accepts a push when the same edge pops.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign do_pop     = bus.RD_EN & ~fifo_empty;
    assign do_push    = commit & (~fifo_full | do_pop);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            sym_q       <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            tmr_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            last_code_q <= CODE_INVALID;
        end else if (bus.CLR) begin
            state_q     <= S_IDLE;
            sym_q       <= '0;
            cnt_q       <= '0;
            inv_q       <= 1'b0;
            tmr_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
            last_code_q <= CODE_INVALID;
        end else begin
            state_q  <= state_d;
            sym_q    <= sym_d;
            cnt_q    <= cnt_d;
            inv_q    <= inv_d;
            tmr_q    <= tmr_d;
            strobe_q <= commit;
            err_q    <= commit && (commit_code == CODE_INVALID);
            if (commit) last_code_q <= commit_code;
            if (commit && fifo_full && !do_pop) overflow_q <= 1'b1;
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push && !bus.CLR) mem[wr_ptr_q] <= commit_code;
    end

    assign bus.RD_DATA   = fifo_empty ? CODE_INVALID : mem[rd_ptr_q];
    assign bus.EMPTY     = fifo_empty;
    assign bus.FULL      = fifo_full;
    assign bus.COUNT     = count_q;
    assign bus.STROBE    = strobe_q;
    assign bus.LAST_CODE = last_code_q;
    assign bus.ERR_CODE  = err_q;
    assign bus.OVERFLOW  = overflow_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_morse_stream_decoder.sv
// tb_morse_stream_decoder
//   Two decoders share one stimulus: dut (DIGITS_EN=1) and dut_nd
//   (DIGITS_EN=0). Expected codes are queued per commit and checked against
//   LAST_CODE/ERR_CODE whenever STROBE fires; FIFO state is checked directly.
module tb_morse_stream_decoder;
    localparam int GAP   = 20;
    localparam int DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    morse_stream_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();
    morse_stream_decoder_if #(.FIFO_DEPTH(DEPTH)) bus_nd ();

    assign bus_nd.CLR      = bus.CLR;
    assign bus_nd.SHORT    = bus.SHORT;
    assign bus_nd.LONG     = bus.LONG;
    assign bus_nd.END_CHAR = bus.END_CHAR;
    assign bus_nd.RD_EN    = bus.RD_EN;

    morse_stream_decoder #(
        .MAX_SYMS(5), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH), .DIGITS_EN(1)
    ) dut (
        .CLK(clk), .RESET_N(rst_n), .bus(bus)
    );

    morse_stream_decoder #(
        .MAX_SYMS(5), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH), .DIGITS_EN(0)
    ) dut_nd (
        .CLK(clk), .RESET_N(rst_n), .bus(bus_nd)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc_cnt  = 0;
    int unsigned last_sym = 0;
    logic [5:0]  exp_q[$];
    logic [5:0]  exp_nd_q[$];
    logic [5:0]  drain_exp[4] = '{6'd19, 6'd4, 6'd19, 6'd0};

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_code(input logic [5:0] d, input logic [5:0] nd);
        exp_q.push_back(d);
        exp_nd_q.push_back(nd);
    endtask

    // Scoreboard: every STROBE pops one expectation per decoder.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.STROBE === 1'b1) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL strobe_unexpected observed=strobe expected=no_strobe");
                end
                if (exp_q.size() != 0) begin
                    logic [5:0] e;
                    e = exp_q.pop_front();
                    chk("last_code", bus.LAST_CODE, e);
                    chk("err_code", bus.ERR_CODE, (e == 6'h3F));
                end
            end else begin
                chk("err_without_strobe", bus.ERR_CODE, 0);
            end
            if (bus_nd.STROBE === 1'b1) begin
                n_checks++;
                assert (exp_nd_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL nd_strobe_unexpected observed=strobe expected=no_strobe");
                end
                if (exp_nd_q.size() != 0) begin
                    logic [5:0] e;
                    e = exp_nd_q.pop_front();
                    chk("nd_last_code", bus_nd.LAST_CODE, e);
                    chk("nd_err_code", bus_nd.ERR_CODE, (e == 6'h3F));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge; inputs are held across exactly one rising edge.
    task automatic cyc(input logic s, input logic l, input logic e,
                       input logic r, input logic c);
        bus.SHORT    = s;
        bus.LONG     = l;
        bus.END_CHAR = e;
        bus.RD_EN    = r;
        bus.CLR      = c;
        @(negedge clk);
        bus.SHORT    = 1'b0;
        bus.LONG     = 1'b0;
        bus.END_CHAR = 1'b0;
        bus.RD_EN    = 1'b0;
        bus.CLR      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop();
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int got;
        int unsigned strobe_cyc;
        bus.SHORT = 1'b0; bus.LONG = 1'b0; bus.END_CHAR = 1'b0;
        bus.RD_EN = 1'b0; bus.CLR = 1'b0;
        rst_n = 1'b0;
        idle(3);

        // Reset values
        chk("rst_count", bus.COUNT, 0);
        chk("rst_empty", bus.EMPTY, 1);
        chk("rst_full", bus.FULL, 0);
        chk("rst_strobe", bus.STROBE, 0);
        chk("rst_err", bus.ERR_CODE, 0);
        chk("rst_overflow", bus.OVERFLOW, 0);
        chk("rst_last_code", bus.LAST_CODE, 6'h3F);
        chk("rst_rd_data", bus.RD_DATA, 6'h3F);
        chk("rst_state", bus.dbg_state, 0);
        rst_n = 1'b1;
        idle(1);

        // 'D' = -.. with explicit END_CHAR
        expect_code(6'd3, 6'd3);
        cyc(0, 1, 0, 0, 0);
        chk("d_state_collect", bus.dbg_state, 1);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        chk("d_state_commit", bus.dbg_state, 2);
        chk("d_empty_before_push", bus.EMPTY, 1);
        idle(1);
        chk("d_strobe", bus.STROBE, 1);
        chk("d_empty_after_push", bus.EMPTY, 0);
        idle(2);
        chk("d_rd_data", bus.RD_DATA, 3);
        chk("d_count", bus.COUNT, 1);
        pop();
        chk("d_popped_empty", bus.EMPTY, 1);
        chk("d_popped_count", bus.COUNT, 0);

        // '1' = .---- closed by the gap timer; gaps shorter than GAP restart it
        expect_code(6'd27, 6'h3F);
        cyc(1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            idle(GAP - 3);
            cyc(0, 1, 0, 0, 0);
        end
        last_sym   = cyc_cnt;
        got        = 0;
        strobe_cyc = 0;
        for (int i = 0; i < GAP + 40; i++) begin
            if (bus.STROBE === 1'b1) begin
                got = 1;
                strobe_cyc = cyc_cnt;
                break;
            end
            @(negedge clk);
        end
        chk("auto_strobe_seen", got, 1);
        chk("auto_latency", strobe_cyc - last_sym, GAP + 1);
        chk("auto_nd_err", bus_nd.ERR_CODE, 1);
        idle(1);
        chk("auto_rd_data", bus.RD_DATA, 27);
        chk("auto_nd_rd_data", bus_nd.RD_DATA, 6'h3F);
        pop();
        chk("auto_empty", bus.EMPTY, 1);

        // Too many symbols, then SHORT+LONG together
        expect_code(6'h3F, 6'h3F);
        repeat (6) cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(1);
        expect_code(6'h3F, 6'h3F);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("inv_count", bus.COUNT, 2);
        chk("inv_rd0", bus.RD_DATA, 6'h3F);
        pop();
        chk("inv_rd1", bus.RD_DATA, 6'h3F);
        pop();

        // END_CHAR alone in IDLE is ignored
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("end_idle_count", bus.COUNT, 0);
        chk("end_idle_state", bus.dbg_state, 0);

        // Symbol during COMMIT of 'T' starts the next character ('E')
        expect_code(6'd19, 6'd19);
        expect_code(6'd4, 6'd4);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("commit_sym_state", bus.dbg_state, 1);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("commit_sym_rd0", bus.RD_DATA, 19);
        pop();
        chk("commit_sym_rd1", bus.RD_DATA, 4);
        pop();

        // Fill with E,T,E,T then overflow with 'A'
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                expect_code(6'd4, 6'd4);
                cyc(1, 0, 0, 0, 0);
            end else begin
                expect_code(6'd19, 6'd19);
                cyc(0, 1, 0, 0, 0);
            end
            cyc(0, 0, 1, 0, 0);
            idle(1);
        end
        idle(1);
        chk("fill_full", bus.FULL, 1);
        chk("fill_count", bus.COUNT, 4);
        chk("fill_overflow_clear", bus.OVERFLOW, 0);
        expect_code(6'd0, 6'd0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("ovf_full", bus.FULL, 1);
        chk("ovf_flag", bus.OVERFLOW, 1);
        chk("ovf_last_code", bus.LAST_CODE, 0);
        chk("ovf_count", bus.COUNT, 4);
        chk("ovf_head", bus.RD_DATA, 4);

        // 'A' committed on the same edge as a pop while full
        expect_code(6'd0, 6'd0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        pop();
        idle(2);
        chk("pp_count", bus.COUNT, 4);
        chk("pp_full", bus.FULL, 1);
        for (int k = 0; k < 4; k++) begin
            chk("pp_drain", bus.RD_DATA, drain_exp[k]);
            pop();
        end
        chk("pp_drained_empty", bus.EMPTY, 1);
        chk("pp_overflow_sticky", bus.OVERFLOW, 1);

        // CLR with three entries queued
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                expect_code(6'd19, 6'd19);
                cyc(0, 1, 0, 0, 0);
            end else begin
                expect_code(6'd4, 6'd4);
                cyc(1, 0, 0, 0, 0);
            end
            cyc(0, 0, 1, 0, 0);
            idle(1);
        end
        idle(1);
        chk("clr_pre_count", bus.COUNT, 3);
        cyc(0, 0, 0, 0, 1);
        chk("clr_empty", bus.EMPTY, 1);
        chk("clr_count", bus.COUNT, 0);
        chk("clr_overflow", bus.OVERFLOW, 0);
        chk("clr_last_code", bus.LAST_CODE, 6'h3F);
        chk("clr_rd_data", bus.RD_DATA, 6'h3F);
        expect_code(6'd13, 6'd13);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("clr_next_rd", bus.RD_DATA, 13);
        pop();

        // Asynchronous reset in the middle of a character
        expect_code(6'd4, 6'd4);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("rstmid_pre_count", bus.COUNT, 1);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rstmid_collect", bus.dbg_state, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_empty", bus.EMPTY, 1);
        chk("rstmid_count", bus.COUNT, 0);
        chk("rstmid_overflow", bus.OVERFLOW, 0);
        chk("rstmid_last_code", bus.LAST_CODE, 6'h3F);
        chk("rstmid_state", bus.dbg_state, 0);
        @(negedge clk);
        idle(1);
        rst_n = 1'b1;
        idle(1);
        expect_code(6'd0, 6'd0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        idle(3);
        chk("rstmid_next_rd", bus.RD_DATA, 0);
        chk("rstmid_next_count", bus.COUNT, 1);
        pop();

        idle(3);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("exp_nd_q_drained", exp_nd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/morse_stream_decoder.md
# morse_stream_decoder

Parametrised successor to the single-letter Morse decoder. Accepts one-cycle SHORT/LONG symbol pulses from the button decoder and an explicit END_CHAR pulse, and also closes a character automatically after an inter-symbol gap timeout. It decodes letters A–Z and, optionally, digits 0–9, then queues the results in a first-word-fall-through FIFO. The VGA/display path drains the FIFO, so a whole message is buffered instead of a single latched letter.

## Interface
- MAX_SYMS, 5, maximum symbols per character; legal range 4..6; must be ≥5 when DIGITS_EN=1
- GAP_CYCLES, 50_000_000, idle cycles after the last symbol that auto-close a character; 0 disables auto-close
- FIFO_DEPTH, 16, decoded-code FIFO entries; power of two, ≥2
- DIGITS_EN, 1, 1 = decode digits 0–9; 0 = five-symbol digit patterns decode as invalid
- CLK  in  1  system clock; all logic is on the rising edge
- RESET_N  in  1  asynchronous, active-low reset
- CLR  in  1  synchronous clear of collector, FIFO and flags
- SHORT  in  1  one-cycle dot pulse
- LONG  in  1  one-cycle dash pulse
- END_CHAR  in  1  one-cycle end-of-character pulse
- RD_EN  in  1  pop head entry
- RD_DATA  out  6  head entry, valid while EMPTY=0
- EMPTY  out  1  FIFO empty
- FULL  out  1  FIFO full
- COUNT  out  $clog2(FIFO_DEPTH)+1  occupancy
- STROBE  out  1  one-cycle pulse per committed character
- LAST_CODE  out  6  most recently committed code
- ERR_CODE  out  1  one-cycle pulse, coincident with STROBE, when the committed code is invalid
- OVERFLOW  out  1  sticky; a commit was dropped because the FIFO was full

## Operation
- Code map: A..Z = 0..25; digits 0..9 = 26..35; invalid = 6'h3F. Uses the standard ITU patterns.
- Collector: the symbol shift register is MAX_SYMS wide, with a symbol count and an invalid flag.
- States:
  - IDLE: count 0. A symbol goes to COLLECT.
  - COLLECT: each symbol is appended and the gap timer restarts. END_CHAR, or the timer reaching GAP_CYCLES, goes to COMMIT.
  - COMMIT: one cycle. Performs the table lookup, pushes the code, pulses STROBE, updates LAST_CODE, then returns to IDLE.
- SHORT and LONG high in the same cycle: no symbol is appended; the invalid flag is set; the pulse counts as a symbol for timer restart and for leaving IDLE.
- More than MAX_SYMS symbols: the invalid flag is set and further symbols are ignored until commit.
- Symbol and END_CHAR in the same cycle in IDLE or COLLECT: the symbol is appended first, then the character commits with it included.
- END_CHAR in IDLE with no symbol: ignored; nothing is pushed.
- Symbol arriving during COMMIT: it becomes the first symbol of the next character; the next state is COLLECT with count 1 and the timer reset.
- FIFO:
  - FWFT: RD_DATA shows the head whenever EMPTY=0, and RD_EN pops it.
  - RD_EN while EMPTY: ignored.
  - Commit while FULL and RD_EN=0: the code is dropped and OVERFLOW is set. STROBE and LAST_CODE still update.
  - Commit while FULL and RD_EN=1: both the pop and the push succeed.
- CLR: clears the collector, timer, FIFO and OVERFLOW, and returns to IDLE. LAST_CODE is set to 6'h3F. CLR has priority over all inputs in that cycle.

## Timing
- Reset values: state IDLE, COUNT=0, EMPTY=1, FULL=0, STROBE=0, ERR_CODE=0, OVERFLOW=0, LAST_CODE=6'h3F, RD_DATA=6'h3F.
- END_CHAR sampled at edge k: COMMIT holds during cycle k..k+1. At edge k+1 the push occurs, STROBE=1 for one cycle, and EMPTY falls if it was empty.
- Auto-close: the last symbol is at edge s, so the timer equals 0 after s. COMMIT is entered at edge s+GAP_CYCLES and the push occurs at s+GAP_CYCLES+1.
- Pop: RD_EN at edge r means RD_DATA shows the next entry, and COUNT decrements, after edge r.
- Reset mid-character: everything returns to reset values asynchronously; the partial character is discarded.

## Test plan
- Reset then LONG, SHORT, SHORT, END_CHAR -> one STROBE; RD_DATA=3 ('D'); COUNT=1; ERR_CODE=0.
- DIGITS_EN=1: SHORT, then LONG×4, then no input for GAP_CYCLES -> STROBE at last symbol +GAP_CYCLES+1; code 27 ('1'). Same stimulus with DIGITS_EN=0 -> code 6'h3F and ERR_CODE pulse.
- Six SHORTs then END_CHAR (MAX_SYMS=5) -> code 6'h3F, ERR_CODE=1. SHORT+LONG in the same cycle then END_CHAR -> 6'h3F.
- Fill FIFO_DEPTH=4 with 'E','T','E','T', then commit 'A' -> FULL=1, OVERFLOW=1, LAST_CODE=0, FIFO contents unchanged. Commit 'A' with RD_EN=1 while full -> COUNT stays 4 and the tail entry is 0.
- END_CHAR in IDLE -> no STROBE. A SHORT during the COMMIT cycle of 'T' -> the next END_CHAR yields 'E' (4).
- Assert RESET_N low during COLLECT, or CLR with 3 entries queued -> EMPTY=1, COUNT=0, OVERFLOW=0, LAST_CODE=6'h3F; the next character decodes cleanly.
